instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the ALU/branch decode path. Accepts one symbolic RV32I operation per handshake
//  (op code, register fields, signed immediate) and builds the 32-bit machine word.
//  Writes words to consecutive instruction-memory locations.
//  Used as the program loader in front of the single-cycle core's instruction memory.
// PARAMETERS
//  ADDR_WIDTH  8      word-address bits; capacity = 2**ADDR_WIDTH instructions
//  BASE_ADDR   32'h0  byte address of the first written word
// PORTS
//  clk       in   1             clock, rising edge
//  reset     in   1             asynchronous, active-low reset
//  clear     in   1             sync: abort current op, zero pointer/count/err
//  in_valid  in   1             request valid
//  in_ready  out  1             encoder can accept; combinational = (state==IDLE) & ~full & ~clear
//  op        in   4             0 add,1 sub,2 and,3 or,4 slt,5 addi,6 andi,7 ori,8 slti,
//                               9 lw,10 sw,11 beq,12 bne,13 blt,14 bge,15 illegal
//  rd        in   5             destination register (ignored for sw/branches)
//  rs1       in   5             source register 1
//  rs2       in   5             source register 2 (ignored for I-type/lw)
//  imm       in   13            signed immediate / branch byte offset
//  mem_we    out  1             instruction-memory write strobe, one cycle per word
//  mem_addr  out  32            byte address = BASE_ADDR + 4*ptr
//  mem_wdata out  32            encoded instruction
//  count     out  ADDR_WIDTH+1  words written since reset/clear
//  full      out  1             count == 2**ADDR_WIDTH
//  err       out  1             sticky; set by illegal op or out-of-range immediate
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; ptr, count, err, mem_we, mem_wdata = 0;
//  mem_addr=BASE_ADDR; full=0. in_ready goes to 1 once reset is released.
//  FSM states:
//   IDLE: in_valid&in_ready -> capture op/rd/rs1/rs2/imm, go to ENC.
//   ENC:  build word and range-check. Legal -> register mem_wdata, go to WR.
//         Illegal -> err<=1, go to IDLE; no write, count unchanged.
//   WR:   mem_we=1 for exactly this cycle. At its closing edge: ptr+=1, count+=1; go to IDLE.
//  Latency: accepted at edge N, mem_we high in cycle N+2 (N+1..N+2). Max 1 word / 3 cycles.
//  Encodings:
//   R-type (0-4): opcode 0110011. funct3 000/000/111/110/010. funct7 0100000 for sub only.
//   I-ALU (5-8):  opcode 0010011, funct3 000/111/110/010.
//   lw:           opcode 0000011, funct3 010.
//   sw:           opcode 0100011, funct3 010, imm split [11:5]/[4:0].
//   Branch:       opcode 1100011, funct3 000/001/100/101,
//                 B-layout {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]}.
//  Range rules (imm as 13-bit signed):
//   I/S-type need -2048..2047.
//   Branches need imm[0]==0 (range -4096..4094 is implicit in the 13-bit width).
//   Violation or op 15 -> err, no write.
//  mem_addr tracks ptr at all times (registered); wraps only via clear, never silently.
//  Full: in_ready=0, requests stall (not dropped). Pointer never wraps past capacity.
//  clear=1 in any state: -> IDLE, ptr=count=err=0, mem_we forced 0 that cycle.
//  clear wins over a simultaneous in_valid; that request is not accepted.
//  Async reset mid-WR: mem_we drops immediately; the in-flight word is lost.
// TESTING
//  1 add x3,x1,x2 -> one mem_we pulse, mem_wdata=0x002081B3, mem_addr=BASE_ADDR, count=1.
//  2 Back-to-back sub x5,x6,x7 / addi x1,x0,-1 / sw x2,8(x1) / beq x1,x2,-8 ->
//    0x407302B3, 0xFFF00093, 0x0020A423, 0xFE208CE3 at +0,+4,+8,+12; in_ready low 2 of every 3 cycles.
//  3 addi imm=2048; beq imm=3; op=15 -> err=1 after first, no mem_we for any, count unchanged.
//  4 ADDR_WIDTH=2: 4 legal ops -> full=1, in_ready=0, 5th held with in_valid=1 and not written;
//    clear -> count=0, full=0, mem_addr=BASE_ADDR, 5th then accepted.
//  5 clear asserted in ENC and in WR -> no write that op, err=0, next request accepted cycle after.
//  6 reset=0 asynchronously while mem_we=1 -> mem_we=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I symbolic-op encoder that loads words into consecutive instruction-memory slots
module instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [12:0]           imm,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
  state_t st;
  logic [3:0] op_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [12:0] imm_q;
  logic we_q;
  logic [2:0] f3;
  logic [6:0] opc;
  logic is_r, is_s, is_b, legal;
  logic [31:0] word;
  // count doubles as the write pointer: it only ever advances by one per written word
  assign full = count == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign in_ready = (st == IDLE) & ~full & ~clear;
  assign mem_we = we_q & ~clear;
  // decode captured op into field values, range-check the immediate and assemble the word
  always_comb begin
    f3 = (op_q == 4'd2 || op_q == 4'd6) ? 3'b111 :
         (op_q == 4'd3 || op_q == 4'd7) ? 3'b110 :
         (op_q == 4'd4 || op_q == 4'd8 || op_q == 4'd9 || op_q == 4'd10) ? 3'b010 :
         (op_q == 4'd12) ? 3'b001 :
         (op_q == 4'd13) ? 3'b100 :
         (op_q == 4'd14) ? 3'b101 : 3'b000;
    is_r = op_q <= 4'd4;
    is_s = op_q == 4'd10;
    is_b = op_q >= 4'd11 && op_q <= 4'd14;
    opc = is_r ? 7'b0110011 :
          (op_q <= 4'd8) ? 7'b0010011 :
          (op_q == 4'd9) ? 7'b0000011 :
          is_s ? 7'b0100011 : 7'b1100011;
    legal = (op_q != 4'd15) & (is_b ? ~imm_q[0] : (is_r | (imm_q[12] == imm_q[11])));
    word = is_r ? {(op_q == 4'd1) ? 7'b0100000 : 7'b0000000, rs2_q, rs1_q, f3, rd_q, opc} :
           is_s ? {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc} :
           is_b ? {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc} :
                  {imm_q[11:0], rs1_q, f3, rd_q, opc};
  end
  // accept -> encode -> write sequencer; clear aborts from any state and rewinds the pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      we_q <= 1'b0;
      mem_wdata <= '0;
      mem_addr <= BASE_ADDR;
      count <= '0;
      err <= 1'b0;
    end else if (clear) begin
      st <= IDLE;
      we_q <= 1'b0;
      mem_addr <= BASE_ADDR;
      count <= '0;
      err <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid && in_ready) begin
          op_q <= op;
          rd_q <= rd;
          rs1_q <= rs1;
          rs2_q <= rs2;
          imm_q <= imm;
          st <= ENC;
        end
        ENC: if (legal) begin
          mem_wdata <= word;
          we_q <= 1'b1;
          st <= WR;
        end else begin
          err <= 1'b1;
          st <= IDLE;
        end
        WR: begin
          we_q <= 1'b0;
          count <= count + 1'b1;
          mem_addr <= BASE_ADDR + 32'({count + 1'b1, 2'b00});
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of encoding, handshake timing, full/clear/error and reset behaviour
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h100;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [3:0] op = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0] imm = '0;
  logic in_ready, mem_we, full, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [31:0] wa[$], wd[$];
  longint wt[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full), .err(err)
  );

  // record every write strobe seen mid low-phase
  always @(negedge clk) begin
    #1;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wt.push_back($time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic clr_q();
    wa.delete(); wd.delete(); wt.delete();
  endtask

  task automatic send(input logic [3:0] o, input logic [4:0] d, s1, s2, input logic [12:0] im, output int n);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1; n = 0;
    #1;
    while (!in_ready && n < 40) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 40) begin failures++; $display("FAIL send_accept got stalled want accepted"); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL rst_addr got %h want %h", mem_addr, BASE); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (err !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL rst_err_full got %b%b want 00", err, full); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int n;
    clr_q();
    send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, n);
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL add_enc got we=%b rdy=%b want 0 0", mem_we, in_ready); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL add_we got %b want 1", mem_we); end
    checks++; if (mem_wdata !== 32'h002081B3) begin failures++; $display("FAIL add_word got %h want 002081b3", mem_wdata); end
    checks++; if (mem_addr !== BASE || in_ready !== 1'b0) begin failures++; $display("FAIL add_addr got %h rdy=%b want %h 0", mem_addr, in_ready, BASE); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || count !== 3'd1) begin failures++; $display("FAIL add_done got we=%b cnt=%0d want 0 1", mem_we, count); end
    checks++; if (mem_addr !== BASE + 32'd4 || in_ready !== 1'b1) begin failures++; $display("FAIL add_next got %h rdy=%b want %h 1", mem_addr, in_ready, BASE + 32'd4); end
    checks++; if (wa.size() != 1) begin failures++; $display("FAIL add_pulses got %0d want 1", wa.size()); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp [4] = '{32'h407302B3, 32'hFFF00093, 32'h0020A423, 32'hFE208CE3};
    do_clear();
    clr_q();
    send(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, n);
    send(4'd5, 5'd1, 5'd0, 5'd0, 13'h1FFF, n);
    send(4'd10, 5'd0, 5'd1, 5'd2, 13'd8, n);
    send(4'd11, 5'd0, 5'd1, 5'd2, 13'h1FF8, n);
    repeat (3) @(negedge clk);
    checks++; if (wa.size() != 4) begin failures++; $display("FAIL b2b_writes got %0d want 4", wa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wd[i] !== exp[i]) begin failures++; $display("FAIL b2b_word%0d got %h want %h", i, wd[i], exp[i]); end
      checks++; if (wa[i] !== BASE + 32'(4 * i)) begin failures++; $display("FAIL b2b_addr%0d got %h want %h", i, wa[i], BASE + 32'(4 * i)); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (wt[i] - wt[i-1] != 30) begin failures++; $display("FAIL b2b_gap%0d got %0d want 30", i, wt[i] - wt[i-1]); end
    end
    checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL b2b_full got f=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count); end
  endtask

  task automatic test_full();
    op = 4'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wa.size() != 4 || count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL full_stall got w=%0d cnt=%0d rdy=%b want 4 4 0", wa.size(), count, in_ready); end
    clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_clr_rdy got %b want 0", in_ready); end
    @(negedge clk); clear = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || full !== 1'b0 || mem_addr !== BASE || in_ready !== 1'b1) begin failures++; $display("FAIL full_cleared got cnt=%0d f=%b a=%h rdy=%b want 0 0 %h 1", count, full, mem_addr, in_ready, BASE); end
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wa.size() != 5) begin failures++; $display("FAIL full_fifth got %0d want 5", wa.size()); end
    else begin
      checks++; if (wa[4] !== BASE || wd[4] !== 32'h002081B3) begin failures++; $display("FAIL full_fifth_word got %h@%h want 002081b3@%h", wd[4], wa[4], BASE); end
    end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL full_count got %0d want 1", count); end
  endtask

  task automatic test_errors();
    int n;
    do_clear();
    clr_q();
    send(4'd5, 5'd1, 5'd0, 5'd0, 13'd2048, n);
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_imm got %b want 1", err); end
    send(4'd11, 5'd0, 5'd1, 5'd2, 13'd3, n);
    repeat (2) @(negedge clk);
    send(4'd15, 5'd1, 5'd1, 5'd1, 13'd0, n);
    repeat (2) @(negedge clk);
    checks++; if (wa.size() != 0 || count !== 3'd0 || err !== 1'b1) begin failures++; $display("FAIL err_nowrite got w=%0d cnt=%0d err=%b want 0 0 1", wa.size(), count, err); end
    send(4'd5, 5'd1, 5'd0, 5'd0, 13'h1800, n);
    repeat (2) @(negedge clk);
    send(4'd11, 5'd0, 5'd1, 5'd2, 13'd4094, n);
    repeat (2) @(negedge clk);
    checks++; if (wa.size() != 2 || count !== 3'd2) begin failures++; $display("FAIL err_edge got w=%0d cnt=%0d want 2 2", wa.size(), count); end
    else begin
      checks++; if (wd[0] !== 32'h80000093) begin failures++; $display("FAIL err_imm_min got %h want 80000093", wd[0]); end
      checks++; if (wd[1] !== 32'h7E208FE3) begin failures++; $display("FAIL err_br_max got %h want 7e208fe3", wd[1]); end
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_clear();
    int n;
    clr_q();
    send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, n);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL clr_enc got err=%b cnt=%0d rdy=%b we=%b want 0 0 1 0", err, count, in_ready, mem_we); end
    send(4'd2, 5'd4, 5'd5, 5'd6, 13'd0, n);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL clr_wr_pre got %b want 1", mem_we); end
    clear = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL clr_wr_we got %b want 0", mem_we); end
    @(negedge clk); clear = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || count !== 3'd0 || wa.size() != 0) begin failures++; $display("FAIL clr_wr_after got rdy=%b cnt=%0d w=%0d want 1 0 0", in_ready, count, wa.size()); end
    send(4'd3, 5'd7, 5'd8, 5'd9, 13'd0, n);
    checks++; if (n != 0) begin failures++; $display("FAIL clr_next_wait got %0d want 0", n); end
    repeat (2) @(negedge clk);
    checks++; if (wa.size() != 1 || count !== 3'd1) begin failures++; $display("FAIL clr_next got w=%0d cnt=%0d want 1 1", wa.size(), count); end
    else begin
      checks++; if (wd[0] !== 32'h009463B3 || wa[0] !== BASE) begin failures++; $display("FAIL clr_next_word got %h@%h want 009463b3@%h", wd[0], wa[0], BASE); end
    end
  endtask

  task automatic test_reset_mid_wr();
    int n;
    send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, n);
    @(negedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL arst_pre got %b want 1", mem_we); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL arst_we got we=%b cnt=%0d want 0 0", mem_we, count); end
    checks++; if (mem_addr !== BASE || mem_wdata !== 32'h0 || err !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL arst_outs got a=%h d=%h e=%b f=%b want %h 0 0 0", mem_addr, mem_wdata, err, full, BASE); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1 || count !== 3'd0 || mem_we !== 1'b0) begin failures++; $display("FAIL arst_release got rdy=%b cnt=%0d we=%b want 1 0 0", in_ready, count, mem_we); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_errors();
    test_clear();
    test_reset_mid_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
